// File: rtl/cache_arbiter.sv
// Two-way physical-memory arbiter between the L1 I-cache (read-only) and L1 D-cache (read/write).
// The winning request is captured into registers and held until the downstream answers.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  input  logic                  i_pmem_read,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,

  output logic                  arb_busy,
  output logic                  arb_grant_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    lastGrantD_q;
  logic [ADDR_WIDTH-1:0]   pmemAddress_q;
  logic                    pmemRead_q;
  logic                    pmemWrite_q;
  logic [LINE_WIDTH-1:0]   pmemWdata_q;

  logic iReq;
  logic dReq;
  logic grantD_d;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    iReq     = i_pmem_read;
    dReq     = d_pmem_read | d_pmem_write;
    grantD_d = dReq & (~iReq | ~lastGrantD_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      lastGrantD_q  <= 1'b1;
      pmemAddress_q <= '0;
      pmemRead_q    <= 1'b0;
      pmemWrite_q   <= 1'b0;
      pmemWdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (iReq || dReq) begin
            lastGrantD_q <= grantD_d;
            if (grantD_d) begin
              state_q       <= SERVE_D;
              pmemAddress_q <= d_pmem_address;
              pmemWrite_q   <= d_pmem_write;
              pmemRead_q    <= ~d_pmem_write;
              pmemWdata_q   <= d_pmem_wdata;
            end else begin
              state_q       <= SERVE_I;
              pmemAddress_q <= i_pmem_address;
              pmemRead_q    <= 1'b1;
              pmemWrite_q   <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          // Returning to IDLE for one cycle keeps a stale request from being re-granted.
          if (pmem_resp) begin
            state_q     <= IDLE;
            pmemRead_q  <= 1'b0;
            pmemWrite_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          pmemRead_q  <= 1'b0;
          pmemWrite_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_address = pmemAddress_q;
  assign pmem_read    = pmemRead_q;
  assign pmem_write   = pmemWrite_q;
  assign pmem_wdata   = pmemWdata_q;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = rst & pmem_resp & (state_q == SERVE_I);
  assign d_pmem_resp  = rst & pmem_resp & (state_q == SERVE_D);

  assign arb_busy     = (state_q != IDLE);
  assign arb_grant_d  = lastGrantD_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter: reset, single I read, D write-back,
// round-robin under contention, held captures and reset mid-transaction.
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  iAddr;
  logic         iRead;
  logic [255:0] iRdata;
  logic         iResp;
  logic [31:0]  dAddr;
  logic         dRead;
  logic         dWrite;
  logic [255:0] dWdata;
  logic [255:0] dRdata;
  logic         dResp;
  logic [31:0]  pAddr;
  logic         pRead;
  logic         pWrite;
  logic [255:0] pWdata;
  logic [255:0] pRdata;
  logic         pResp;
  logic         busy;
  logic         grantD;

  int compareCount = 0;
  int failCount    = 0;

  cache_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_address (iAddr),
    .i_pmem_read    (iRead),
    .i_pmem_rdata   (iRdata),
    .i_pmem_resp    (iResp),
    .d_pmem_address (dAddr),
    .d_pmem_read    (dRead),
    .d_pmem_write   (dWrite),
    .d_pmem_wdata   (dWdata),
    .d_pmem_rdata   (dRdata),
    .d_pmem_resp    (dResp),
    .pmem_address   (pAddr),
    .pmem_read      (pRead),
    .pmem_write     (pWrite),
    .pmem_wdata     (pWdata),
    .pmem_rdata     (pRdata),
    .pmem_resp      (pResp),
    .arb_busy       (busy),
    .arb_grant_d    (grantD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [255:0] lineA5;
    logic [255:0] lineBeef;
    logic [255:0] lineRd;
    lineA5   = {32{8'hA5}};
    lineBeef = {8{32'hDEADBEEF}};

    rst    = 1'b0;
    iAddr  = 32'h0000_1000;
    iRead  = 1'b1;
    dAddr  = 32'h8000_0040;
    dRead  = 1'b1;
    dWrite = 1'b0;
    dWdata = '0;
    pRdata = '0;
    pResp  = 1'b0;

    // Reset held three cycles with both requesters active.
    repeat (3) applyStimulus();
    checkOutput("rst_pmem_read",  pRead,  0);
    checkOutput("rst_pmem_write", pWrite, 0);
    checkOutput("rst_pmem_addr",  pAddr,  0);
    checkOutput("rst_pmem_wdata", pWdata, 0);
    checkOutput("rst_i_resp",     iResp,  0);
    checkOutput("rst_d_resp",     dResp,  0);
    checkOutput("rst_busy",       busy,   0);
    checkOutput("rst_grant_d",    grantD, 1);

    // Release: tie resolved toward I because last grant was D.
    rst = 1'b1;
    applyStimulus();
    checkOutput("first_grant_read", pRead,  1);
    checkOutput("first_grant_addr", pAddr,  32'h0000_1000);
    checkOutput("first_grant_d",    grantD, 0);
    checkOutput("first_busy",       busy,   1);
    iRead = 1'b0;
    dRead = 1'b0;
    repeat (4) applyStimulus();
    checkOutput("iread_held", pRead, 1);
    pResp  = 1'b1;
    pRdata = lineA5;
    #1;
    checkOutput("iread_resp",   iResp,  1);
    checkOutput("iread_rdata",  iRdata, lineA5);
    checkOutput("iread_d_resp", dResp,  0);
    applyStimulus();
    pResp = 1'b0;
    #1;
    checkOutput("iread_resp_gone", iResp, 0);
    checkOutput("iread_idle",      busy,  0);
    checkOutput("iread_read_clr",  pRead, 0);

    // Downstream response in IDLE must not reach either cache.
    pResp = 1'b1;
    #1;
    checkOutput("idle_i_resp", iResp, 0);
    checkOutput("idle_d_resp", dResp, 0);
    pResp = 1'b0;

    // D write-back with read also asserted: write wins.
    dAddr  = 32'h8000_0040;
    dWdata = lineBeef;
    dWrite = 1'b1;
    dRead  = 1'b1;
    applyStimulus();
    checkOutput("dwr_write",   pWrite, 1);
    checkOutput("dwr_read",    pRead,  0);
    checkOutput("dwr_addr",    pAddr,  32'h8000_0040);
    checkOutput("dwr_wdata",   pWdata, lineBeef);
    checkOutput("dwr_grant_d", grantD, 1);
    dAddr  = 32'h1234_5678;
    dWdata = '0;
    dWrite = 1'b0;
    applyStimulus();
    checkOutput("dwr_addr_held",  pAddr,  32'h8000_0040);
    checkOutput("dwr_wdata_held", pWdata, lineBeef);
    checkOutput("dwr_write_held", pWrite, 1);
    checkOutput("dwr_read_low",   pRead,  0);
    dRead = 1'b0;
    pResp = 1'b1;
    #1;
    checkOutput("dwr_d_resp", dResp, 1);
    checkOutput("dwr_i_resp", iResp, 0);
    applyStimulus();
    pResp = 1'b0;
    #1;
    checkOutput("dwr_write_clr", pWrite, 0);
    checkOutput("dwr_idle",      busy,   0);

    // Continuous contention: expect I, D, I, D with an IDLE turnaround between each.
    iAddr = 32'h0000_2000;
    dAddr = 32'h0000_3000;
    iRead = 1'b1;
    dRead = 1'b1;
    for (int n = 0; n < 4; n++) begin
      logic expectD;
      expectD = n[0];
      applyStimulus();
      checkOutput($sformatf("rr%0d_grant_d", n), grantD, expectD);
      checkOutput($sformatf("rr%0d_read", n),    pRead,  1);
      checkOutput($sformatf("rr%0d_addr", n),    pAddr,  expectD ? 32'h0000_3000 : 32'h0000_2000);
      applyStimulus();
      lineRd = {8{32'h0000_0100 + n}};
      pRdata = lineRd;
      pResp  = 1'b1;
      #1;
      checkOutput($sformatf("rr%0d_i_resp", n), iResp, !expectD);
      checkOutput($sformatf("rr%0d_d_resp", n), dResp, expectD);
      checkOutput($sformatf("rr%0d_rdata", n),  expectD ? dRdata : iRdata, lineRd);
      applyStimulus();
      pResp = 1'b0;
      #1;
      checkOutput($sformatf("rr%0d_turnaround", n), busy,  0);
      checkOutput($sformatf("rr%0d_read_clr", n),   pRead, 0);
    end
    iRead = 1'b0;
    dRead = 1'b0;
    applyStimulus();
    checkOutput("rr_quiet", busy, 0);

    // Reset during SERVE_I abandons the transaction; a late response is dropped.
    iAddr = 32'h0000_4000;
    iRead = 1'b1;
    applyStimulus();
    checkOutput("mid_serve_read", pRead, 1);
    rst = 1'b0;
    applyStimulus();
    checkOutput("mid_rst_read",   pRead,  0);
    checkOutput("mid_rst_busy",   busy,   0);
    checkOutput("mid_rst_i_resp", iResp,  0);
    checkOutput("mid_rst_grant",  grantD, 1);
    rst   = 1'b1;
    iRead = 1'b0;
    pResp = 1'b1;
    #1;
    checkOutput("late_i_resp", iResp, 0);
    checkOutput("late_d_resp", dResp, 0);
    applyStimulus();
    checkOutput("late_busy", busy, 0);
    pResp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
